// File: rtl/note_pkg.sv
// Shared types and constants for the note judge and its score keeper.
// Latency: n/a (declarations only).
// Backpressure: n/a; the judge consumes one note row per eighth-beat and never stalls.
package note_pkg;

  localparam int NOTE_W          = 5;
  localparam int MAX_MULT        = 4;
  localparam int DEF_HIT_POINTS  = 10;
  localparam int DEF_STREAK_STEP = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // song not loaded, everything held clear
    EMPTY  = 2'd1,  // target row holds no note
    ARMED  = 2'd2,  // target row holds a note not yet judged
    JUDGED = 2'd3   // target row already hit or missed
  } judge_state_e;

  // Multiplier tier: 1 + streak/step, capped at MAX_MULT.
  function automatic logic [2:0] mult_of(input logic [7:0] streak, input logic [7:0] step);
    logic [7:0] tier;
    tier = streak / step;
    if (tier >= 8'(MAX_MULT - 1)) begin
      return 3'(MAX_MULT);
    end
    return 3'(tier + 8'd1);
  endfunction

endpackage

// File: rtl/note_judge_score_keeper.sv
// Streak, multiplier and saturating score registers driven by judge events.
// Latency: streak/score update on the edge that registers the event; multiplier follows streak combinationally.
// Backpressure: none; accepts at most one event per cycle, clr has priority.
//
// Ports:
//   clk, resetn        clock and asynchronous active-low reset
//   hit_evt, miss_evt  judgement outcome for this cycle (mutually exclusive)
//   clr                synchronous clear back to the reset values
//   streak             consecutive hits, saturating at 255
//   multiplier         1..MAX_MULT, derived from the registered streak
//   score              accumulated points, saturating at 16'hFFFF
module score_keeper
  import note_pkg::*;
#(
  parameter int HIT_POINTS  = DEF_HIT_POINTS,
  parameter int STREAK_STEP = DEF_STREAK_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hit_evt,
  input  logic        miss_evt,
  input  logic        clr,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier,
  output logic [15:0] score
);

  logic [7:0]  streak_q, streak_d;
  logic [15:0] score_q, score_d;
  logic [16:0] pts;
  logic [16:0] sum;

  assign multiplier = mult_of(streak_q, 8'(STREAK_STEP));

  always_comb begin
    // Points use the multiplier in force before this hit bumps the streak.
    pts      = 17'(HIT_POINTS) * 17'(multiplier);
    sum      = {1'b0, score_q} + pts;
    streak_d = streak_q;
    score_d  = score_q;
    if (clr) begin
      streak_d = '0;
      score_d  = '0;
    end else if (hit_evt) begin
      streak_d = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
      score_d  = sum[16] ? 16'hFFFF : sum[15:0];
    end else if (miss_evt) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_q <= '0;
      score_q  <= '0;
    end else begin
      streak_q <= streak_d;
      score_q  <= score_d;
    end
  end

  assign streak = streak_q;
  assign score  = score_q;

endmodule

// File: rtl/note_judge.sv
// Scrolling note highway plus strum judge; grades the bottom row and keeps score.
// Latency: hit/miss and score registered one cycle after the strum or eight_beat edge.
// Backpressure: none; one row is accepted per eight_beat, one judgement per row.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   eight_beat           single-cycle step pulse; shifts the highway
//   load                 song active; low clears everything and idles
//   exp_notes[4:0]       row entering the highway on the next step (bit4 = leftmost fret)
//   frets[4:0], strum    player inputs, already synchronised/debounced
//   highway              row r at bits [5r+4:5r]; row HIGHWAY_DEPTH-1 is the target
//   hit, miss            one-cycle judgement pulses, never together
//   streak, multiplier, score   from the score keeper
// Build option: define NOTE_JUDGE_OVERSTRUM_EN to make a strum on an empty target count as a miss.
module note_judge
  import note_pkg::*;
#(
  parameter int HIGHWAY_DEPTH = 8,   // legal range 2..16
  parameter int HIT_POINTS    = DEF_HIT_POINTS,
  parameter int STREAK_STEP   = DEF_STREAK_STEP
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              eight_beat,
  input  logic                              load,
  input  logic [NOTE_W-1:0]                 exp_notes,
  input  logic [NOTE_W-1:0]                 frets,
  input  logic                              strum,
  output logic [NOTE_W*HIGHWAY_DEPTH-1:0]   highway,
  output logic                              hit,
  output logic                              miss,
  output logic [7:0]                        streak,
  output logic [2:0]                        multiplier,
  output logic [15:0]                       score
);

  localparam int HW_W = NOTE_W * HIGHWAY_DEPTH;

  judge_state_e      state_q, state_d;
  logic [HW_W-1:0]   highway_q, highway_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              clr;
  logic              judged;
  logic [NOTE_W-1:0] target;
  logic [NOTE_W-1:0] next_target;

  assign target      = highway_q[HW_W-1 -: NOTE_W];
  // Row that becomes the target once the current shift completes.
  assign next_target = highway_q[HW_W-NOTE_W-1 -: NOTE_W];

  always_comb begin
    state_d   = state_q;
    highway_d = highway_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    clr       = 1'b0;
    judged    = 1'b0;
    if (!load) begin
      state_d   = IDLE;
      highway_d = '0;
      clr       = 1'b1;
    end else if (state_q == IDLE) begin
      // First loaded cycle only arms the judge; inputs still ignored.
      state_d = EMPTY;
    end else begin
      // Strum is judged against the pre-shift target, before any shift below.
      if (strum) begin
        case (state_q)
          ARMED: begin
            judged  = 1'b1;
            state_d = JUDGED;
            if (frets == target) begin
              hit_d = 1'b1;
            end else begin
              miss_d = 1'b1;
            end
          end
          EMPTY: begin
`ifdef NOTE_JUDGE_OVERSTRUM_EN
            miss_d = 1'b1;
`endif
          end
          default: begin
          end
        endcase
      end
      if (eight_beat) begin
        highway_d = {highway_q[HW_W-NOTE_W-1:0], exp_notes};
        // A note leaving unjudged is a passed-note miss; a row judged
        // in this same cycle already produced its pulse.
        if (state_q == ARMED && !judged) begin
          miss_d = 1'b1;
        end
        state_d = (next_target != '0) ? ARMED : EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      highway_q <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      highway_q <= highway_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  score_keeper #(
    .HIT_POINTS  (HIT_POINTS),
    .STREAK_STEP (STREAK_STEP)
  ) u_score_keeper (
    .clk        (clk),
    .resetn     (resetn),
    .hit_evt    (hit_d),
    .miss_evt   (miss_d),
    .clr        (clr),
    .streak     (streak),
    .multiplier (multiplier),
    .score      (score)
  );

  assign highway = highway_q;
  assign hit     = hit_q;
  assign miss    = miss_q;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge with a pulse scoreboard.
// Stimulus pushes the expected judgement for every strum/shift; the monitor pops on each hit/miss.
// Direct checks cover reset, scrolling, idle behaviour, saturation and load clear.
module tb_note_judge;

  localparam int D = 8;
  localparam logic [4:0] P = 5'b10100;

  logic           clk = 1'b0;
  logic           resetn;
  logic           eight_beat;
  logic           load;
  logic [4:0]     exp_notes;
  logic [4:0]     frets;
  logic           strum;
  logic [5*D-1:0] highway;
  logic           hit;
  logic           miss;
  logic [7:0]     streak;
  logic [2:0]     multiplier;
  logic [15:0]    score;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_hit;
    logic [7:0]  st;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   m_streak;
  int   m_score;

  note_judge #(.HIGHWAY_DEPTH(D), .HIT_POINTS(10), .STREAK_STEP(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .eight_beat (eight_beat),
    .load       (load),
    .exp_notes  (exp_notes),
    .frets      (frets),
    .strum      (strum),
    .highway    (highway),
    .hit        (hit),
    .miss       (miss),
    .streak     (streak),
    .multiplier (multiplier),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [2:0] ref_mult(input int s);
    int t;
    t = 1 + s / 8;
    return (t > 4) ? 3'd4 : 3'(t);
  endfunction

  task automatic push_hit();
    int mlt;
    mlt = ref_mult(m_streak);
    m_score = m_score + 10 * mlt;
    if (m_score > 65535) m_score = 65535;
    if (m_streak < 255) m_streak++;
    q.push_back({1'b1, 8'(m_streak), 16'(m_score)});
  endtask

  task automatic push_miss();
    m_streak = 0;
    q.push_back({1'b0, 8'(m_streak), 16'(m_score)});
  endtask

  // Drive one cycle of inputs from a negedge; returns at the next negedge
  // where the registered response is visible.
  task automatic tick(input logic eb, input logic st, input logic [4:0] fr, input logic [4:0] ex);
    eight_beat = eb;
    strum      = st;
    frets      = fr;
    exp_notes  = ex;
    @(negedge clk);
    eight_beat = 1'b0;
    strum      = 1'b0;
  endtask

  // Monitor: every pulse must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (hit || miss) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {62'd0, hit, miss}, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("pulse_kind", {62'd0, hit, miss}, e.is_hit ? 64'd2 : 64'd1);
          check("pulse_streak", streak, e.st);
          check("pulse_score", score, e.sc);
          check("pulse_mult", multiplier, ref_mult(int'(e.st)));
        end
      end
    end
  end

  initial begin
    logic [5*D-1:0] hw_exp;
    resetn = 1'b0; load = 1'b0; eight_beat = 1'b0; strum = 1'b0;
    frets = '0; exp_notes = '0;
    m_streak = 0; m_score = 0;
    #3;
    check("rst_highway", highway, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_streak", streak, 0);
    check("rst_mult", multiplier, 1);
    check("rst_score", score, 0);
    @(negedge clk);
    resetn = 1'b1;

    // load low: strums and beats ignored
    for (int i = 0; i < 4; i++) tick(i[0], 1'b1, P, 5'b11111);
    tick(0, 0, 0, 0);
    check("idle_highway", highway, 0);
    check("idle_score", score, 0);

    // scroll a single note to the target row
    load = 1'b1;
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 5'b00101);
    check("scroll_0", highway, 40'h5);
    for (int k = 1; k < 8; k++) begin
      tick(1, 0, 0, 0);
      hw_exp = 40'h5 << (5 * k);
      check("scroll_k", highway, hw_exp);
    end
    // unstrummed ARMED note leaves: passed-note miss
    push_miss();
    tick(1, 0, 0, 0);
    check("scroll_out", highway, 0);
    tick(0, 0, 0, 0);

    // fill highway with P
    for (int i = 0; i < 8; i++) tick(1, 0, 0, P);
    check("fill_highway", highway, {8{P}});

    // 9 strums, each together with a beat: single hit each, no passed miss
    for (int i = 0; i < 9; i++) begin
      push_hit();
      tick(1, 1, P, P);
    end
    check("hits9_streak", streak, 9);
    check("hits9_mult", multiplier, 2);
    check("hits9_score", score, 100);

    // plain strum, then a repeat strum on the judged row
    push_hit();
    tick(0, 1, P, P);
    check("hit10_score", score, 120);
    check("hit10_streak", streak, 10);
    tick(0, 1, P, P);
    tick(1, 0, 0, P);
    tick(0, 0, 0, P);

    // wrong frets, repeat strum ignored, then passed note
    push_miss();
    tick(0, 1, 5'b01010, P);
    check("wrong_streak", streak, 0);
    check("wrong_score", score, 120);
    tick(0, 1, P, P);
    tick(1, 0, 0, P);
    push_miss();
    tick(1, 0, 0, P);
    tick(0, 0, 0, P);

    // asynchronous reset mid-song
    check("pre_reset_score", score, 120);
    #2 resetn = 1'b0;
    #1;
    check("arst_highway", highway, 0);
    check("arst_hit", hit, 0);
    check("arst_miss", miss, 0);
    check("arst_streak", streak, 0);
    check("arst_mult", multiplier, 1);
    check("arst_score", score, 0);
    m_streak = 0; m_score = 0;
    @(negedge clk);
    resetn = 1'b1;
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);

    // strum on an EMPTY target
`ifdef NOTE_JUDGE_OVERSTRUM_EN
    push_miss();
`endif
    tick(0, 1, 5'b00001, 0);
    tick(0, 0, 0, 0);
    check("empty_strum_score", score, 0);

    // long hit run: streak and score saturate
    for (int i = 0; i < 8; i++) tick(1, 0, 0, P);
    for (int i = 0; i < 1660; i++) begin
      push_hit();
      tick(1, 1, P, P);
    end
    tick(0, 0, 0, P);
    check("sat_score", score, 16'hFFFF);
    check("sat_streak", streak, 255);
    check("sat_mult", multiplier, 4);

    // load falls: everything cleared on the next edge
    load = 1'b0;
    tick(0, 0, 0, 0);
    check("unload_highway", highway, 0);
    check("unload_score", score, 0);
    check("unload_streak", streak, 0);
    check("unload_mult", multiplier, 1);
    tick(0, 0, 0, 0);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
